fan_duty_sched: RTL and testbench
=================================

FAN_DUTY_SCHED -- requirements
Module: fan_duty_sched

Interface
REQ-001 Parameter TICK_DIV, default 50000, sys_clk cycles per 1 ms tick (50 MHz clock).
REQ-002 Parameter STEP_MS, default 20, ms between successive 1 % duty steps while ramping.
REQ-003 Parameter KICK_MS, default 300, ms of 100 % spin-up kick when leaving stop.
REQ-004 Parameter MAN_TO_MS, default 30000, ms without a manual command before manual mode is revoked.
REQ-005 sys_clk  in  1  system clock, all logic on rising edge.
REQ-006 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 tgt_duty  in  7  requested duty % from the speed/temperature mapper; values >100 are treated as 100.
REQ-008 fan_en  in  1  fan enable; low forces stop.
REQ-009 man_req  in  1  manual-mode bit as unpacked from the host command.
REQ-010 cmd_valid  in  1  one-cycle pulse, a new host command was unpacked.
REQ-011 pwm_duty  out  7  scheduled duty % (0..100) for the PWM generator.
REQ-012 mode_out  out  1  effective mode bit for the mapper (1 = manual).
REQ-013 state  out  2  FSM state: 0 IDLE, 1 KICK, 2 RAMP, 3 HOLD.
REQ-014 ramp_busy  out  1  high in KICK or RAMP.

Function
REQ-015 A free-running prescaler SHALL emit a one-cycle tick every TICK_DIV clocks, counting from reset release.
REQ-016 Effective target tgt_eff SHALL be min(tgt_duty, 100), sampled every clock; no arithmetic may wrap past 0 or 100.
REQ-017 IDLE: pwm_duty=0; when fan_en=1 and tgt_eff>0, next clock -> KICK, pwm_duty=100, kick counter cleared.
REQ-018 KICK: pwm_duty held at 100; after KICK_MS ticks -> RAMP with step counter cleared.
REQ-019 RAMP: at every STEP_MS-th tick, pwm_duty SHALL move exactly 1 toward tgt_eff; when pwm_duty==tgt_eff (checked every clock) -> HOLD.
REQ-020 RAMP with tgt_eff=0: ramp down by steps; on pwm_duty reaching 0 -> IDLE.
REQ-021 HOLD: pwm_duty unchanged; if tgt_eff!=pwm_duty -> RAMP with step counter cleared (first step after full STEP_MS).
REQ-022 Target change during RAMP SHALL redirect the ramp without restarting the step counter.
REQ-023 fan_en=0 in any state SHALL force IDLE and pwm_duty=0 on the next clock, overriding all other conditions.
REQ-024 Manual watchdog: counter cleared on cmd_valid; increments per tick while man_req=1 and not expired; at MAN_TO_MS sets expired.
REQ-025 mode_out = man_req AND NOT expired, registered; cmd_valid clears expired; cmd_valid coincident with expiry tick: cmd_valid wins.
REQ-026 man_req=0 SHALL clear the watchdog counter and expired flag.
REQ-027 ramp_busy and state SHALL be registered, consistent with the FSM state in the same cycle.

Reset
REQ-028 On sys_rst_n low, asynchronously: state=IDLE, pwm_duty=0, mode_out=0, ramp_busy=0, all counters and expired flag cleared.
REQ-029 Reset asserted mid-KICK or mid-RAMP SHALL abort immediately; after release the block restarts from IDLE with a fresh prescaler phase.

Verification (TICK_DIV=4, STEP_MS=2, KICK_MS=5, MAN_TO_MS=10)
REQ-030 fan_en=1, tgt_duty=0->97 -> KICK, pwm_duty=100 for 5 ticks (20 clk), then RAMP 100->97 at one step per 8 clk, HOLD at 97, ramp_busy low.
REQ-031 In HOLD at 97, tgt_duty=120 -> tgt_eff=100, RAMP to 100 in 3 steps (24 clk), never exceeds 100.
REQ-032 In HOLD at 40, tgt_duty=0 -> ramp down to 0 over 40 steps, then IDLE; no KICK re-entered.
REQ-033 Mid-RAMP at 60, fan_en=0 -> next clock pwm_duty=0, state=IDLE; fan_en=1 again -> KICK.
REQ-034 man_req=1, cmd_valid pulse, no further commands -> mode_out=1 for 10 ticks then 0; cmd_valid on expiry tick -> mode_out stays 1.
REQ-035 Reset asserted in KICK -> outputs zero within same cycle; after release with fan_en=1, tgt_duty=50 -> full KICK then ramp to 50.

Source files
------------

// File: rtl/fan_duty_sched.sv
// fan_duty_sched: fan duty scheduler. Kicks a stopped fan at 100 %, then
// ramps the PWM duty 1 % per STEP_MS toward the requested target and holds
// it there. A manual-mode watchdog revokes manual mode when the host stops
// sending commands for MAN_TO_MS.
module fan_duty_sched #(
   parameter int TICK_DIV  = 50000,
   parameter int STEP_MS   = 20,
   parameter int KICK_MS   = 300,
   parameter int MAN_TO_MS = 30000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [6:0] i_tgt_duty,
   input  logic       i_fan_en,
   input  logic       i_man_req,
   input  logic       i_cmd_valid,
   output logic [6:0] o_pwm_duty,
   output logic       o_mode_out,
   output logic [1:0] o_state,
   output logic       o_ramp_busy
);

   // Counter widths, kept at least one bit wide for degenerate parameters
   localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
   localparam int SW = (STEP_MS   > 1) ? $clog2(STEP_MS)   : 1;
   localparam int KW = (KICK_MS   > 1) ? $clog2(KICK_MS)   : 1;
   localparam int WW = (MAN_TO_MS > 1) ? $clog2(MAN_TO_MS) : 1;

   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STEP_MAX  = SW'(STEP_MS - 1);
   localparam logic [KW-1:0] KICK_MAX  = KW'(KICK_MS - 1);
   localparam logic [WW-1:0] WD_MAX    = WW'(MAN_TO_MS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_KICK = 2'd1,
      S_RAMP = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   logic [PW-1:0] r_presc;
   logic [SW-1:0] r_step_cnt;
   logic [KW-1:0] r_kick_cnt;
   logic [WW-1:0] r_wd_cnt;
   logic          r_expired;
   logic          r_mode_out;
   state_t        r_state;
   logic [6:0]    r_pwm_duty;
   logic          r_ramp_busy;

   logic          w_tick;
   logic [6:0]    w_tgt_eff;

   assign w_tick    = (r_presc == PRESC_MAX);
   // Targets above 100 % saturate so the ramp can never go past full duty
   assign w_tgt_eff = (i_tgt_duty > 7'd100) ? 7'd100 : i_tgt_duty;

   // Free-running 1 ms prescaler; phase restarts at reset release
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         r_presc <= '0;
      else if (w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + 1'b1;
   end

   // Duty FSM: state, duty and busy flag are all updated together so the
   // outputs always describe the same state
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state     <= S_IDLE;
         r_pwm_duty  <= 7'd0;
         r_ramp_busy <= 1'b0;
         r_kick_cnt  <= '0;
         r_step_cnt  <= '0;
      end else if (!i_fan_en) begin
         r_state     <= S_IDLE;
         r_pwm_duty  <= 7'd0;
         r_ramp_busy <= 1'b0;
         r_kick_cnt  <= '0;
         r_step_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_pwm_duty  <= 7'd0;
               r_ramp_busy <= 1'b0;
               if (w_tgt_eff != 7'd0) begin
                  r_state     <= S_KICK;
                  r_pwm_duty  <= 7'd100;
                  r_ramp_busy <= 1'b1;
                  r_kick_cnt  <= '0;
               end
            end
            S_KICK: begin
               if (w_tick) begin
                  if (r_kick_cnt == KICK_MAX) begin
                     r_state    <= S_RAMP;
                     r_step_cnt <= '0;
                  end else begin
                     r_kick_cnt <= r_kick_cnt + 1'b1;
                  end
               end
            end
            S_RAMP: begin
               // Arrival is checked every clock so a target change that meets
               // the current duty ends the ramp at once
               if (r_pwm_duty == w_tgt_eff) begin
                  r_state     <= (w_tgt_eff == 7'd0) ? S_IDLE : S_HOLD;
                  r_ramp_busy <= 1'b0;
               end else if (w_tick) begin
                  if (r_step_cnt == STEP_MAX) begin
                     r_step_cnt <= '0;
                     if (r_pwm_duty < w_tgt_eff)
                        r_pwm_duty <= r_pwm_duty + 7'd1;
                     else
                        r_pwm_duty <= r_pwm_duty - 7'd1;
                  end else begin
                     r_step_cnt <= r_step_cnt + 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (w_tgt_eff != r_pwm_duty) begin
                  r_state     <= S_RAMP;
                  r_ramp_busy <= 1'b1;
                  r_step_cnt  <= '0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_pwm_duty  <= 7'd0;
               r_ramp_busy <= 1'b0;
            end
         endcase
      end
   end

   // Manual-mode watchdog; a host command on the expiry tick keeps manual mode
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_wd_cnt   <= '0;
         r_expired  <= 1'b0;
         r_mode_out <= 1'b0;
      end else begin
         r_mode_out <= i_man_req & ~r_expired;
         if (!i_man_req || i_cmd_valid) begin
            r_wd_cnt  <= '0;
            r_expired <= 1'b0;
         end else if (w_tick && !r_expired) begin
            if (r_wd_cnt == WD_MAX)
               r_expired <= 1'b1;
            else
               r_wd_cnt <= r_wd_cnt + 1'b1;
         end
      end
   end

   assign o_pwm_duty  = r_pwm_duty;
   assign o_mode_out  = r_mode_out;
   assign o_state     = r_state;
   assign o_ramp_busy = r_ramp_busy;

endmodule

// File: tb/tb_fan_duty_sched.sv
// tb_fan_duty_sched: directed checks of kick, ramp, hold, stop, reset abort
// and the manual-mode watchdog, using short timing parameters.
module tb_fan_duty_sched;

   logic       sys_clk;
   logic       sys_rst_n;
   logic [6:0] i_tgt_duty;
   logic       i_fan_en;
   logic       i_man_req;
   logic       i_cmd_valid;
   logic [6:0] o_pwm_duty;
   logic       o_mode_out;
   logic [1:0] o_state;
   logic       o_ramp_busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int over_cnt = 0;
   int saw_kick;

   fan_duty_sched #(
      .TICK_DIV (4),
      .STEP_MS  (2),
      .KICK_MS  (5),
      .MAN_TO_MS(10)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .i_tgt_duty (i_tgt_duty),
      .i_fan_en   (i_fan_en),
      .i_man_req  (i_man_req),
      .i_cmd_valid(i_cmd_valid),
      .o_pwm_duty (o_pwm_duty),
      .o_mode_out (o_mode_out),
      .o_state    (o_state),
      .o_ramp_busy(o_ramp_busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Duty must never exceed 100 %
   always @(negedge sys_clk)
      if (sys_rst_n && o_pwm_duty > 7'd100) over_cnt++;

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_checks++;
      if (obs != exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, obs, exp_v, cyc);
      end else begin
         $display("ok   %s: %0d (cyc %0d)", tag, obs, cyc);
      end
   endtask

   // Advance to 1 time unit after rising edge number t since reset release
   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge sys_clk);
         cyc++;
         #1;
      end
   endtask

   initial begin
      sys_rst_n   = 1'b0;
      i_tgt_duty  = 7'd0;
      i_fan_en    = 1'b1;
      i_man_req   = 1'b0;
      i_cmd_valid = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rst_pwm",   o_pwm_duty,  0);
      chk("rst_state", o_state,     0);
      chk("rst_busy",  o_ramp_busy, 0);
      chk("rst_mode",  o_mode_out,  0);
      sys_rst_n = 1'b1;
      cyc = 0;

      // Start from stop: kick then ramp down to 97
      goto(2);
      chk("idle_tgt0_state", o_state, 0);
      i_tgt_duty = 7'd97;
      goto(3);
      chk("kick_state", o_state, 1);
      chk("kick_pwm",   o_pwm_duty, 100);
      chk("kick_busy",  o_ramp_busy, 1);
      goto(19);
      chk("kick_end_state", o_state, 1);
      goto(20);
      chk("ramp_entry_state", o_state, 2);
      chk("ramp_entry_pwm",   o_pwm_duty, 100);
      goto(27);
      chk("ramp_pre_step_pwm", o_pwm_duty, 100);
      goto(28);
      chk("ramp_step1_pwm", o_pwm_duty, 99);
      goto(44);
      chk("ramp_97_pwm",   o_pwm_duty, 97);
      chk("ramp_97_state", o_state, 2);
      goto(45);
      chk("hold97_state", o_state, 3);
      chk("hold97_busy",  o_ramp_busy, 0);

      // Over-range target saturates at 100
      i_tgt_duty = 7'd120;
      goto(46);
      chk("sat_ramp_state", o_state, 2);
      goto(52);
      chk("sat_step1_pwm", o_pwm_duty, 98);
      goto(68);
      chk("sat_step3_pwm", o_pwm_duty, 100);
      goto(69);
      chk("sat_hold_state", o_state, 3);

      // Down to 40, then to 0 with no re-kick
      i_tgt_duty = 7'd40;
      goto(548);
      chk("down40_pwm", o_pwm_duty, 40);
      goto(549);
      chk("hold40_state", o_state, 3);
      i_tgt_duty = 7'd0;
      saw_kick = 0;
      for (int c = 550; c <= 868; c++) begin
         goto(c);
         if (o_state == 2'd1) saw_kick = 1;
      end
      chk("down0_pwm",   o_pwm_duty, 0);
      chk("down0_state", o_state, 2);
      chk("down0_nokick", saw_kick, 0);
      goto(869);
      chk("stop_idle_state", o_state, 0);
      chk("stop_idle_busy",  o_ramp_busy, 0);
      goto(875);
      chk("stop_stays_idle", o_state, 0);

      // Mid-ramp fan disable, then re-enable
      goto(876);
      i_tgt_duty = 7'd50;
      goto(1216);
      chk("mid60_pwm",   o_pwm_duty, 60);
      chk("mid60_state", o_state, 2);
      i_fan_en = 1'b0;
      goto(1217);
      chk("disable_pwm",   o_pwm_duty, 0);
      chk("disable_state", o_state, 0);
      chk("disable_busy",  o_ramp_busy, 0);
      i_fan_en = 1'b1;
      goto(1218);
      chk("reenable_state", o_state, 1);
      chk("reenable_pwm",   o_pwm_duty, 100);

      // Reset during kick aborts immediately
      goto(1220);
      chk("pre_rst_state", o_state, 1);
      sys_rst_n = 1'b0;
      #1;
      chk("async_rst_pwm",   o_pwm_duty, 0);
      chk("async_rst_state", o_state, 0);
      chk("async_rst_busy",  o_ramp_busy, 0);
      @(posedge sys_clk);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      cyc = 0;
      goto(1);
      chk("rkick_state", o_state, 1);
      goto(19);
      chk("rkick_end_state", o_state, 1);
      goto(20);
      chk("rramp_state", o_state, 2);
      goto(420);
      chk("r50_pwm", o_pwm_duty, 50);
      goto(421);
      chk("r50_hold_state", o_state, 3);

      // Manual watchdog
      goto(422);
      i_man_req   = 1'b1;
      i_cmd_valid = 1'b1;
      goto(423);
      i_cmd_valid = 1'b0;
      chk("man_on", o_mode_out, 1);
      goto(460);
      chk("man_last", o_mode_out, 1);
      goto(461);
      chk("man_expired", o_mode_out, 0);
      goto(470);
      chk("man_stays_off", o_mode_out, 0);
      goto(471);
      i_cmd_valid = 1'b1;
      goto(472);
      i_cmd_valid = 1'b0;
      goto(473);
      chk("man_renewed", o_mode_out, 1);
      goto(511);
      i_cmd_valid = 1'b1;
      goto(512);
      i_cmd_valid = 1'b0;
      goto(513);
      chk("man_cmd_on_expiry", o_mode_out, 1);
      goto(552);
      chk("man_last2", o_mode_out, 1);
      goto(553);
      chk("man_expired2", o_mode_out, 0);
      goto(555);
      i_man_req = 1'b0;
      goto(558);
      chk("man_req_low", o_mode_out, 0);
      i_man_req = 1'b1;
      goto(559);
      chk("man_req_reraise", o_mode_out, 1);

      chk("pwm_le_100", over_cnt, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Run-time bound
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
